// File: rtl/ntt_stream_ctrl.sv
// ntt_stream_ctrl: load/run/unload sequencer between a coefficient stream,
// a single-port-pair coefficient memory and an NTT core.
module ntt_stream_ctrl #(
    parameter int N  = 256,
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          ntt_start,
    input  logic          ntt_done,
    input  logic          ntt_en_w,
    input  logic          ntt_en_r,
    input  logic [AW-1:0] ntt_addr_w,
    input  logic [AW-1:0] ntt_addr_r,
    input  logic [DW-1:0] ntt_data_w,
    output logic [DW-1:0] ntt_data_r,
    output logic          en_w,
    output logic          en_r,
    output logic [AW-1:0] addr_w,
    output logic [AW-1:0] addr_r,
    output logic [DW-1:0] data_w,
    input  logic [DW-1:0] data_r,
    output logic          busy,
    output logic [15:0]   run_cycles
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_UNLOAD = 2'd3;

    localparam int          LAST_I = N - 1;
    localparam logic [AW:0] LAST   = LAST_I[AW:0];
    localparam logic [AW:0] NCNT   = N[AW:0];

    logic [1:0]    r_state;
    logic [AW:0]   r_ld_cnt;
    logic [AW:0]   r_rd_cnt;
    logic [AW:0]   r_out_cnt;
    logic          r_inflight;
    logic [DW-1:0] r_fifo [2];
    logic          r_wp;
    logic          r_rp;
    logic [1:0]    r_fcnt;
    logic          r_start;
    logic [15:0]   r_run_cycles;

    logic          w_in_ready;
    logic          w_ld_acc;
    logic          w_ld_last;
    logic          w_pop;
    logic          w_out_last;
    logic [2:0]    w_occ;
    logic          w_rd_issue;

    assign w_in_ready = !rst && (r_state == S_IDLE || r_state == S_LOAD);
    assign w_ld_acc   = in_valid && w_in_ready;
    assign w_ld_last  = w_ld_acc && (r_ld_cnt == LAST);
    assign w_pop      = (r_fcnt != 2'd0) && out_ready;
    assign w_out_last = w_pop && (r_out_cnt == LAST);

    // A beat leaving this cycle frees its slot now, which keeps full rate.
    assign w_occ = {1'b0, r_fcnt} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_rd_issue = (r_state == S_UNLOAD) && (w_occ < 3'd2)
                        && (r_rd_cnt < NCNT);

    assign in_ready   = w_in_ready;
    assign out_valid  = (r_fcnt != 2'd0);
    assign out_data   = r_fifo[r_rp];
    assign ntt_start  = r_start;
    assign ntt_data_r = data_r;
    assign busy       = (r_state != S_IDLE);
    assign run_cycles = r_run_cycles;

    always_comb begin
        en_w   = 1'b0;
        addr_w = '0;
        data_w = '0;
        en_r   = 1'b0;
        addr_r = '0;
        case (r_state)
            S_IDLE, S_LOAD: begin
                en_w   = w_ld_acc;
                addr_w = r_ld_cnt[AW-1:0];
                data_w = in_data;
            end
            S_RUN: begin
                en_w   = ntt_en_w;
                addr_w = ntt_addr_w;
                data_w = ntt_data_w;
                en_r   = ntt_en_r;
                addr_r = ntt_addr_r;
            end
            S_UNLOAD: begin
                en_r   = w_rd_issue;
                addr_r = r_rd_cnt[AW-1:0];
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ld_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_out_cnt    <= '0;
            r_start      <= 1'b0;
            r_run_cycles <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_ld_last) begin
                        r_state      <= S_RUN;
                        r_ld_cnt     <= '0;
                        r_start      <= 1'b1;
                        r_run_cycles <= '0;
                    end else if (w_ld_acc) begin
                        r_state  <= S_LOAD;
                        r_ld_cnt <= r_ld_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_run_cycles != 16'hFFFF)
                        r_run_cycles <= r_run_cycles + 16'd1;
                    if (ntt_done)
                        r_state <= S_UNLOAD;
                end
                S_UNLOAD: begin
                    if (w_out_last) begin
                        r_state   <= S_IDLE;
                        r_rd_cnt  <= '0;
                        r_out_cnt <= '0;
                    end else begin
                        if (w_rd_issue)
                            r_rd_cnt <= r_rd_cnt + 1'b1;
                        if (w_pop)
                            r_out_cnt <= r_out_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Memory read data lands one cycle after en_r, tracked by r_inflight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_fcnt     <= '0;
        end else begin
            r_inflight <= w_rd_issue;
            if (r_inflight) begin
                r_fifo[r_wp] <= data_r;
                r_wp         <= ~r_wp;
            end
            if (w_pop)
                r_rp <= ~r_rp;
            r_fcnt <= r_fcnt + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_ntt_stream_ctrl.sv
// Scoreboard bench for ntt_stream_ctrl: queued expected writes and output
// beats, checked by a negedge monitor against a behavioural memory.
module tb_ntt_stream_ctrl;

    localparam int N  = 256;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          ntt_start;
    logic          ntt_done;
    logic          ntt_en_w;
    logic          ntt_en_r;
    logic [AW-1:0] ntt_addr_w;
    logic [AW-1:0] ntt_addr_r;
    logic [DW-1:0] ntt_data_w;
    logic [DW-1:0] ntt_data_r;
    logic          en_w;
    logic          en_r;
    logic [AW-1:0] addr_w;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] data_w;
    logic [DW-1:0] data_r = '0;
    logic          busy;
    logic [15:0]   run_cycles;

    logic [DW-1:0] mem     [N];
    logic [DW-1:0] exp_mem [N];
    logic [23:0]   wq [$];
    logic [15:0]   oq [$];
    logic [23:0]   w_e;
    logic [15:0]   o_e;
    logic [15:0]   held;
    logic          stall;
    logic          run_ph;
    int            occ;
    int            n_vec;
    int            n_err;

    ntt_stream_ctrl #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .ntt_start(ntt_start), .ntt_done(ntt_done),
        .ntt_en_w(ntt_en_w), .ntt_en_r(ntt_en_r),
        .ntt_addr_w(ntt_addr_w), .ntt_addr_r(ntt_addr_r),
        .ntt_data_w(ntt_data_w), .ntt_data_r(ntt_data_r),
        .en_w(en_w), .en_r(en_r), .addr_w(addr_w), .addr_r(addr_r),
        .data_w(data_w), .data_r(data_r),
        .busy(busy), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (en_w) mem[addr_w] <= data_w;
        if (en_r) data_r <= mem[addr_r];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            occ   = 0;
            stall = 1'b0;
        end else begin
            if (en_w) begin
                if (wq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, expected none",
                             addr_w, data_w);
                end else begin
                    w_e = wq.pop_front();
                    chk("wr_addr", 32'(addr_w), 32'(w_e[23:16]));
                    chk("wr_data", 32'(data_w), 32'(w_e[15:0]));
                end
            end
            if (stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (oq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_beat: got %0h, expected none", out_data);
                end else begin
                    o_e = oq.pop_front();
                    chk("out_data", 32'(out_data), 32'(o_e));
                end
            end
            if (!run_ph && (en_r || (out_valid && out_ready))) begin
                occ = occ + (en_r ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
                chk("occupancy_le2", 32'(occ <= 2), 32'd1);
            end
            stall = out_valid && !out_ready;
            held  = out_data;
        end
    end

    task automatic core_idle();
        ntt_en_w   = 1'b1;
        ntt_addr_w = 8'hEE;
        ntt_data_w = 16'hDEAD;
        ntt_en_r   = 1'b1;
        ntt_addr_r = 8'h77;
    endtask

    task automatic load_poly(input int gap, input logic [15:0] x, input bit spur);
        int k;
        int c;
        logic [15:0] d;
        k = 0;
        c = 0;
        while (k < N) begin
            ntt_done = spur && (c == 7 || c == 8);
            if (c % gap == 0) begin
                d = 16'(k) ^ x;
                in_valid = 1'b1;
                in_data  = d;
                wq.push_back({8'(k), d});
                exp_mem[k] = d;
                k++;
            end else begin
                in_valid = 1'b0;
                in_data  = 16'hFFFF;
            end
            @(negedge clk);
            if (in_valid) chk("in_ready_load", 32'(in_ready), 32'd1);
            if (k == N) begin
                chk("start_low_last_beat", 32'(ntt_start), 32'd0);
                chk("busy_load", 32'(busy), 32'd1);
            end
            @(posedge clk); #1;
            c++;
        end
        in_valid = 1'b0;
        ntt_done = 1'b0;
        chk("wq_empty_after_load", 32'(wq.size()), 32'd0);
    endtask

    task automatic run_core(input int dly);
        run_ph = 1'b1;
        for (int c = 0; c <= dly; c++) begin
            ntt_done   = (c == dly);
            ntt_en_w   = (c == 10);
            ntt_addr_w = 8'h12;
            ntt_data_w = exp_mem[8'h12];
            if (c == 10) wq.push_back({8'h12, exp_mem[8'h12]});
            ntt_en_r   = (c == 20);
            ntt_addr_r = 8'h34;
            @(negedge clk);
            if (c == 0) begin
                chk("start_pulse", 32'(ntt_start), 32'd1);
                chk("busy_run", 32'(busy), 32'd1);
                chk("in_ready_run", 32'(in_ready), 32'd0);
            end
            if (c == 1) chk("start_single", 32'(ntt_start), 32'd0);
            if (c == 20) begin
                chk("run_en_r", 32'(en_r), 32'd1);
                chk("run_addr_r", 32'(addr_r), 32'h34);
            end
            if (c == 21) chk("run_data_r", 32'(ntt_data_r), 32'(exp_mem[8'h34]));
            if (c == dly)
                for (int i = 0; i < N; i++) oq.push_back(exp_mem[i]);
            @(posedge clk); #1;
        end
        run_ph   = 1'b0;
        ntt_done = 1'b0;
        core_idle();
        @(negedge clk);
        chk("run_cycles", 32'(run_cycles), 32'(dly + 1));
        chk("unload_first_en_r", 32'(en_r), 32'd1);
        chk("unload_first_addr", 32'(addr_r), 32'd0);
        chk("start_low_unload", 32'(ntt_start), 32'd0);
        chk("in_ready_unload", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic unload(input int mode, input int stop_at);
        int pops;
        int cyc;
        int first;
        int last;
        pops  = 0;
        cyc   = 0;
        first = -1;
        last  = -1;
        while (pops < stop_at && cyc < 5000) begin
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (first < 0) first = cyc;
                last = cyc;
                pops++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        chk("unload_beats", 32'(pops), 32'(stop_at));
        if (mode == 0 && stop_at == N)
            chk("full_rate_span", 32'(last - first), 32'(N - 1));
        if (stop_at == N) begin
            out_ready = 1'b0;
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_in_ready", 32'(in_ready), 32'd1);
            chk("oq_empty", 32'(oq.size()), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        run_ph    = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        out_ready = 1'b1;
        ntt_done  = 1'b0;
        core_idle();
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(ntt_start), 32'd0);
        chk("rst_en_w", 32'(en_w), 32'd0);
        chk("rst_en_r", 32'(en_r), 32'd0);
        chk("rst_run_cycles", 32'(run_cycles), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        load_poly(1, 16'h0000, 1'b0);
        run_core(40);
        unload(0, N);

        load_poly(3, 16'hA5A5, 1'b1);
        run_core(40);
        unload(1, N);

        load_poly(1, 16'h3C00, 1'b0);
        run_core(0);
        unload(0, 100);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_en_r", 32'(en_r), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        oq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle_ready", 32'(in_ready), 32'd1);
        chk("midrst_idle_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        load_poly(1, 16'h5A00, 1'b0);
        run_core(5);
        unload(1, N);

        chk("wq_final_empty", 32'(wq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ntt_stream_ctrl.md
NTT_STREAM_CTRL -- requirements
Module: ntt_stream_ctrl

Interface
REQ-001 SHALL have parameters: N, 256, polynomial length; AW, 8, address width (log2 N); DW, 16, coefficient width.
REQ-002 SHALL have ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  load-stream beat valid.
- in_data  in  DW  load coefficient.
- in_ready  out  1  load beat accepted when in_valid&in_ready.
- out_valid  out  1  unload beat valid.
- out_data  out  DW  unload coefficient.
- out_ready  in  1  unload beat consumed when out_valid&out_ready.
- ntt_start  out  1  one-cycle pulse starting the NTT core.
- ntt_done  in  1  NTT core completion pulse.
- ntt_en_w, ntt_en_r  in  1  core memory write/read enables.
- ntt_addr_w, ntt_addr_r  in  AW  core memory addresses.
- ntt_data_w  in  DW  core write data.
- ntt_data_r  out  DW  read data to core.
- en_w, en_r  out  1  coefficient-memory write/read enables.
- addr_w, addr_r  out  AW  memory addresses.
- data_w  out  DW  memory write data.
- data_r  in  DW  memory read data, valid one cycle after en_r.
- busy  out  1  high in any state other than IDLE.
- run_cycles  out  16  clock cycles spent in RUN for the last/current transform.

Function
REQ-003 SHALL implement states IDLE, LOAD, RUN, UNLOAD.
REQ-004 in_ready SHALL be 1 in IDLE and LOAD, 0 otherwise.
REQ-005 Each accepted load beat SHALL write in_data to address ld_cnt the same cycle (en_w=1, addr_w=ld_cnt[AW-1:0], data_w=in_data); ld_cnt (AW+1 bits) increments per beat.
REQ-006 IDLE->LOAD on first accepted beat; LOAD->RUN on the cycle the N-th beat is accepted; ld_cnt clears at that transition.
REQ-007 ntt_start SHALL pulse high for exactly the first cycle in RUN.
REQ-008 In RUN, en_w/addr_w/data_w/en_r/addr_r SHALL combinationally follow ntt_en_w/ntt_addr_w/ntt_data_w/ntt_en_r/ntt_addr_r; outside RUN core requests SHALL be ignored.
REQ-009 ntt_data_r SHALL equal data_r at all times.
REQ-010 RUN->UNLOAD on ntt_done=1; ntt_done in any other state SHALL be ignored; ntt_done coinciding with ntt_start cycle SHALL still transition.
REQ-011 run_cycles SHALL clear on entering RUN, increment each RUN cycle including the ntt_done cycle, saturate at 16'hFFFF, and hold outside RUN.
REQ-012 UNLOAD SHALL read addresses 0..N-1 in order into a 2-entry output FIFO; a read issues (en_r=1, addr_r=rd_cnt) only when fifo_count + reads_in_flight < 2 and rd_cnt < N.
REQ-013 out_valid SHALL be 1 iff FIFO is non-empty; out_data is the FIFO head; back-to-back beats at full rate SHALL be sustained while out_ready=1.
REQ-014 out_valid/out_data SHALL stay stable while out_valid&!out_ready.
REQ-015 UNLOAD->IDLE on the cycle the N-th output beat is consumed; all counters clear.
REQ-016 en_w and en_r SHALL be 0 in IDLE, in LOAD when no beat is accepted, and in UNLOAD except as per REQ-012 (en_w always 0 in UNLOAD).
REQ-017 busy SHALL be 0 in IDLE, 1 otherwise (including the LOAD->RUN transition cycle's successor).

Reset
REQ-018 rst=1 SHALL asynchronously force IDLE, clear ld_cnt, rd_cnt, FIFO, in-flight flag, run_cycles to 0.
REQ-019 During reset: in_ready=0, out_valid=0, ntt_start=0, en_w=0, en_r=0, busy=0; in_ready rises the first cycle after rst deasserts.
REQ-020 Reset mid-operation (any state) SHALL abandon the transform; no partial output beat survives.

Verification
REQ-021 Load 0x0000..0x00FF with in_valid held -> 256 writes addr k data k, ntt_start single pulse the cycle after the 256th accept, busy=1.
REQ-022 Core model asserts ntt_done 40 cycles after ntt_start -> run_cycles=41, memory port follows core only during RUN, UNLOAD entered next cycle.
REQ-023 Unload with out_ready=1 constantly -> 256 beats data 0..255 in order, one per cycle after first, IDLE after last, busy=0.
REQ-024 Unload with out_ready toggling 1/0 randomly -> data order preserved, no beat duplicated or dropped, out_data stable while stalled, never more than 2 reads outstanding+buffered.
REQ-025 Load with gapped in_valid (1 of 3 cycles) -> exactly 256 writes, addresses contiguous; spurious ntt_done in LOAD ignored.
REQ-026 Assert rst at beat 100 of UNLOAD -> out_valid=0 immediately, state IDLE, next load starts at address 0.
